// File: rtl/tx_mod_if.sv
// rtl/tx_mod_if.sv - request/done handshake between the interface block and tx_mod
interface tx_mod_if #(
  parameter int NB_DATA = 8
);
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_din;
  logic               o_tx_done_tick;
  logic               o_busy;

  modport slave (
    input  i_tx_start,
    input  i_din,
    output o_tx_done_tick,
    output o_busy
  );

  modport master (
    output i_tx_start,
    output i_din,
    input  o_tx_done_tick,
    input  o_busy
  );
endinterface

// File: rtl/tx_mod.sv
// rtl/tx_mod.sv - UART transmitter, 16x oversampled, LSB first, no parity
module tx_mod #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 1,
  parameter int SB_TICK = 16
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_s_tick,
  output logic    o_tx,
  tx_mod_if.slave bus
);
  localparam int S_W = (SB_TICK * NB_STOP > 1) ? $clog2(SB_TICK * NB_STOP) : 1;
  localparam int N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(SB_TICK - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK * NB_STOP - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_state;
  logic [S_W-1:0]     r_s;
  logic [N_W-1:0]     r_n;
  logic [NB_DATA-1:0] r_b;
  logic               r_tx;
  logic               r_done;
  logic               r_busy;

  // r_tx is loaded with the value of the state being entered so the line
  // changes in the same cycle as the state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (bus.i_tx_start) begin
            r_b     <= bus.i_din;
            r_s     <= '0;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s     <= '0;
              r_n     <= '0;
              r_state <= DATA;
              r_tx    <= r_b[0];
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s <= '0;
              r_b <= r_b >> 1;
              if (r_n == N_LAST) begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end else begin
                r_n  <= r_n + N_W'(1);
                r_tx <= r_b[1];
              end
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end
        STOP: begin
          if (i_s_tick) begin
            if (r_s == S_STOP_LAST) begin
              r_s     <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx               = r_tx;
  assign bus.o_tx_done_tick = r_done;
  assign bus.o_busy         = r_busy;
endmodule

// File: tb/tb_tx_mod.sv
// tb/tb_tx_mod.sv - directed self-checking bench for tx_mod
module tb_tx_mod;
  logic clk = 1'b0;
  logic rst_n;
  logic s_tick;
  logic tx;

  tx_mod_if #(.NB_DATA(8)) bus ();

  tx_mod #(.NB_DATA(8), .NB_STOP(1), .SB_TICK(16)) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_s_tick (s_tick),
    .o_tx     (tx),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int per     = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs for the new cycle are applied 1ns after the edge.
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    s_tick = (per == 1) ? 1'b1 : ((cyc % per) == 0);
    bus.i_tx_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    while ((cyc % per) != 0) step;
    bus.i_din      = d;
    bus.i_tx_start = 1'b1;
  endtask

  // pat[j] is the line level of bit j in time order: start, 8 data, stop.
  task automatic frame_check(input string tag, input logic [9:0] pat, input int inj_off,
                             input bit b2b, input logic [7:0] nxt);
    int d;
    int done_off;
    int bad_done;
    bad_done = 0;
    step;
    d = (per - (cyc % per)) % per;
    done_off = d + per * 159 + 1;
    chk($sformatf("%s start tx/busy", tag), {30'b0, tx, bus.o_busy}, 32'h1);
    for (int off = 0; off <= done_off; off++) begin
      if (off > 0) step;
      for (int j = 0; j < 10; j++)
        if (off == d + 16 * per * j + 7 * per)
          chk($sformatf("%s bit%0d", tag, j), {31'b0, tx}, {31'b0, pat[j]});
      if (off == d + 16 * per * 5) chk($sformatf("%s busy mid", tag), {31'b0, bus.o_busy}, 32'h1);
      if (off < done_off && bus.o_tx_done_tick !== 1'b0) bad_done++;
      if (off == inj_off) begin
        bus.i_tx_start = 1'b1;
        bus.i_din      = 8'hFF;
      end
      if (off == done_off) begin
        chk($sformatf("%s done", tag), {31'b0, bus.o_tx_done_tick}, 32'h1);
        chk($sformatf("%s busy end", tag), {31'b0, bus.o_busy}, 32'h0);
        chk($sformatf("%s tx end", tag), {31'b0, tx}, 32'h1);
        if (b2b) begin
          bus.i_tx_start = 1'b1;
          bus.i_din      = nxt;
        end
      end
    end
    chk($sformatf("%s early done", tag), bad_done, 0);
    if (!b2b) begin
      step;
      chk($sformatf("%s done width", tag), {31'b0, bus.o_tx_done_tick}, 32'h0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    s_tick         = 1'b0;
    bus.i_tx_start = 1'b0;
    bus.i_din      = 8'h00;

    for (int i = 0; i < 5; i++) begin
      step;
      chk("reset hold", {29'b0, tx, bus.o_busy, bus.o_tx_done_tick}, 32'h4);
    end
    rst_n = 1'b1;
    step;
    chk("reset release", {29'b0, tx, bus.o_busy, bus.o_tx_done_tick}, 32'h4);

    // start coincides with a tick: the 640-clock timing only holds if that tick is ignored
    send(8'hA5);
    frame_check("a5", 10'b1101001010, -1, 1'b0, 8'h00);

    send(8'h3C);
    frame_check("3c", 10'b1001111000, 200, 1'b0, 8'h00);

    send(8'hFF);
    frame_check("ff", 10'b1111111110, -1, 1'b1, 8'h00);
    frame_check("00", 10'b1000000000, -1, 1'b0, 8'h00);

    send(8'h55);
    step;
    for (int i = 0; i < 287; i++) step;
    chk("abort pre tx", {31'b0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("abort async tx", {31'b0, tx}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("abort hold", {29'b0, tx, bus.o_busy, bus.o_tx_done_tick}, 32'h4);
    end
    rst_n          = 1'b1;
    bus.i_din      = 8'h81;
    bus.i_tx_start = 1'b1;
    frame_check("81", 10'b1100000010, -1, 1'b0, 8'h00);

    per = 1;
    step;
    send(8'h5A);
    frame_check("5a", 10'b1010110100, -1, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
